// File: rtl/pll_drp_regs.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pll_drp_regs - PLLE2-style DRP register file with clock-counter field decode
// Revision 1.0 - initial release
// ----------------------------------------------------------------------------
module pll_drp_regs #(
  parameter int CLKFBOUT_MULT = 5,
  parameter int DIVCLK_DIVIDE = 1,
  parameter int CLKOUT_DIVIDE = 1
) (
  input  logic        i_dclk,
  input  logic        i_rst,
  input  logic        i_pwrdwn,
  input  logic [6:0]  i_daddr,
  input  logic        i_den,
  input  logic        i_dwe,
  input  logic [15:0] i_di,
  output logic [15:0] o_do,
  output logic        o_drdy,
  output logic [32:0] o_clkout0_divide,
  output logic [32:0] o_clkout1_divide,
  output logic [32:0] o_clkout2_divide,
  output logic [32:0] o_clkout3_divide,
  output logic [32:0] o_clkout4_divide,
  output logic [32:0] o_clkout5_divide,
  output logic [32:0] o_clkout0_duty_cycle_1000,
  output logic [32:0] o_clkout1_duty_cycle_1000,
  output logic [32:0] o_clkout2_duty_cycle_1000,
  output logic [32:0] o_clkout3_duty_cycle_1000,
  output logic [32:0] o_clkout4_duty_cycle_1000,
  output logic [32:0] o_clkout5_duty_cycle_1000,
  output logic [32:0] o_clkout0_phase,
  output logic [32:0] o_clkout1_phase,
  output logic [32:0] o_clkout2_phase,
  output logic [32:0] o_clkout3_phase,
  output logic [32:0] o_clkout4_phase,
  output logic [32:0] o_clkout5_phase,
  output logic [32:0] o_clkfbout_mult,
  output logic [32:0] o_clkfbout_phase,
  output logic [32:0] o_divclk_divide
);

  localparam logic [7:0]  c_out_d  = 8'(CLKOUT_DIVIDE);
  localparam logic [7:0]  c_fb_d   = 8'(CLKFBOUT_MULT);
  localparam logic [7:0]  c_dv_d   = 8'(DIVCLK_DIVIDE);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT1 = 2'd1;
  localparam logic [1:0] S_WAIT2 = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  function automatic logic [15:0] f_enc_r1(input logic [7:0] d);
    logic [5:0] hi, lo;
    hi = d[6:1];
    lo = d[5:0] - hi;
    return (d == 8'd1) ? 16'h0041 : {4'b0, hi, lo};
  endfunction

  function automatic logic [15:0] f_enc_r2(input logic [7:0] d);
    return (d == 8'd1) ? 16'h0040 : {8'b0, d[0], 7'b0};
  endfunction

  function automatic logic [15:0] f_enc_div(input logic [7:0] d);
    logic [5:0] hi, lo;
    hi = d[6:1];
    lo = d[5:0] - hi;
    return (d == 8'd1) ? 16'h1041 : {2'b0, d[0], 1'b0, hi, lo};
  endfunction

  function automatic logic [15:0] f_reset(input logic [6:0] a);
    case (a)
      7'h06, 7'h08, 7'h0A, 7'h0C, 7'h0E, 7'h10: return f_enc_r1(c_out_d);
      7'h07, 7'h09, 7'h0B, 7'h0D, 7'h0F, 7'h11: return f_enc_r2(c_out_d);
      7'h14:   return f_enc_r1(c_fb_d);
      7'h15:   return f_enc_r2(c_fb_d);
      7'h16:   return f_enc_div(c_dv_d);
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic f_mapped(input logic [6:0] a);
    return (a >= 7'h06 && a <= 7'h11) || (a >= 7'h14 && a <= 7'h16) ||
           (a >= 7'h18 && a <= 7'h1A) || a == 7'h28 || a == 7'h4E || a == 7'h4F;
  endfunction

  // A zero HIGH/LOW count encodes 64.
  function automatic logic [32:0] f_cnt(input logic [5:0] v);
    return (v == 6'd0) ? 33'd64 : {27'b0, v};
  endfunction

  function automatic logic [32:0] f_div(input logic [5:0] hi, input logic [5:0] lo, input logic nc);
    return nc ? 33'd1 : f_cnt(hi) + f_cnt(lo);
  endfunction

  function automatic logic [32:0] f_duty(input logic [5:0] hi, input logic [5:0] lo,
                                         input logic eg, input logic nc);
    if (nc) return 33'd500;
    return (33'd1000 * (33'd2 * f_cnt(hi) + {32'b0, eg})) / (33'd2 * f_div(hi, lo, nc));
  endfunction

  function automatic logic [32:0] f_phase(input logic [2:0] pm, input logic [5:0] dly,
                                          input logic [5:0] hi, input logic [5:0] lo, input logic nc);
    return (({27'b0, dly} * 33'd8 + {30'b0, pm}) * 33'd45000) / f_div(hi, lo, nc);
  endfunction

  logic        w_rst;
  logic        w_accept;
  logic [1:0]  r_state;
  logic [6:0]  r_addr;
  logic [15:0] r_do;
  logic        r_drdy;
  logic [15:0] r_regs [128];

  logic [32:0] w_co_div [6];
  logic [32:0] w_co_duty [6];
  logic [32:0] w_co_phase [6];
  logic [32:0] r_co_div [6];
  logic [32:0] r_co_duty [6];
  logic [32:0] r_co_phase [6];
  logic [32:0] r_fb_mult, r_fb_phase, r_dv_div;

  assign w_rst    = i_rst | i_pwrdwn;
  assign w_accept = i_den && (r_state == S_IDLE || r_state == S_DONE);

  always_ff @(posedge i_dclk) begin
    if (w_rst) begin
      for (int a = 0; a < 128; a++) r_regs[a] <= f_reset(7'(a));
      r_state <= S_IDLE;
      r_addr  <= 7'd0;
      r_do    <= 16'd0;
      r_drdy  <= 1'b0;
    end else begin
      r_do   <= 16'd0;
      r_drdy <= 1'b0;
      case (r_state)
        S_WAIT1: r_state <= S_WAIT2;
        S_WAIT2: begin
          r_do    <= r_regs[r_addr];
          r_drdy  <= 1'b1;
          r_state <= S_DONE;
        end
        default: begin
          if (w_accept) begin
            r_state <= S_WAIT1;
            r_addr  <= i_daddr;
            if (i_dwe && f_mapped(i_daddr)) r_regs[i_daddr] <= i_di;
          end else begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  // CLKOUT5 sits below CLKOUT0 in the map.
  for (genvar n = 0; n < 6; n++) begin : g_clkout
    localparam logic [6:0] c_base = (n == 5) ? 7'h06 : 7'(8 + 2 * n);
    assign w_co_div[n]   = f_div(r_regs[c_base][11:6], r_regs[c_base][5:0], r_regs[c_base + 7'd1][6]);
    assign w_co_duty[n]  = f_duty(r_regs[c_base][11:6], r_regs[c_base][5:0],
                                  r_regs[c_base + 7'd1][7], r_regs[c_base + 7'd1][6]);
    assign w_co_phase[n] = f_phase(r_regs[c_base][15:13], r_regs[c_base + 7'd1][5:0],
                                   r_regs[c_base][11:6], r_regs[c_base][5:0], r_regs[c_base + 7'd1][6]);
  end

  always_ff @(posedge i_dclk) begin
    if (w_rst) begin
      for (int n = 0; n < 6; n++) begin
        r_co_div[n]   <= 33'(CLKOUT_DIVIDE);
        r_co_duty[n]  <= 33'd500;
        r_co_phase[n] <= 33'd0;
      end
      r_fb_mult  <= 33'(CLKFBOUT_MULT);
      r_fb_phase <= 33'd0;
      r_dv_div   <= 33'(DIVCLK_DIVIDE);
    end else begin
      for (int n = 0; n < 6; n++) begin
        r_co_div[n]   <= w_co_div[n];
        r_co_duty[n]  <= w_co_duty[n];
        r_co_phase[n] <= w_co_phase[n];
      end
      r_fb_mult  <= f_div(r_regs[7'h14][11:6], r_regs[7'h14][5:0], r_regs[7'h15][6]);
      r_fb_phase <= f_phase(r_regs[7'h14][15:13], r_regs[7'h15][5:0],
                            r_regs[7'h14][11:6], r_regs[7'h14][5:0], r_regs[7'h15][6]);
      r_dv_div   <= f_div(r_regs[7'h16][11:6], r_regs[7'h16][5:0], r_regs[7'h16][12]);
    end
  end

  assign o_do   = r_do;
  assign o_drdy = r_drdy;
  assign o_clkout0_divide = r_co_div[0];
  assign o_clkout1_divide = r_co_div[1];
  assign o_clkout2_divide = r_co_div[2];
  assign o_clkout3_divide = r_co_div[3];
  assign o_clkout4_divide = r_co_div[4];
  assign o_clkout5_divide = r_co_div[5];
  assign o_clkout0_duty_cycle_1000 = r_co_duty[0];
  assign o_clkout1_duty_cycle_1000 = r_co_duty[1];
  assign o_clkout2_duty_cycle_1000 = r_co_duty[2];
  assign o_clkout3_duty_cycle_1000 = r_co_duty[3];
  assign o_clkout4_duty_cycle_1000 = r_co_duty[4];
  assign o_clkout5_duty_cycle_1000 = r_co_duty[5];
  assign o_clkout0_phase = r_co_phase[0];
  assign o_clkout1_phase = r_co_phase[1];
  assign o_clkout2_phase = r_co_phase[2];
  assign o_clkout3_phase = r_co_phase[3];
  assign o_clkout4_phase = r_co_phase[4];
  assign o_clkout5_phase = r_co_phase[5];
  assign o_clkfbout_mult  = r_fb_mult;
  assign o_clkfbout_phase = r_fb_phase;
  assign o_divclk_divide  = r_dv_div;

endmodule
`default_nettype wire

// File: tb/tb_pll_drp_regs.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_pll_drp_regs - self-checking bench for the DRP register file and decode
// Revision 1.0 - initial release
// ----------------------------------------------------------------------------
module tb_pll_drp_regs;

  logic        clk = 1'b0;
  logic        rst, pwrdwn, den, dwe;
  logic [6:0]  daddr;
  logic [15:0] di;
  logic [15:0] dout;
  logic        drdy;
  logic [32:0] co_div [6];
  logic [32:0] co_duty [6];
  logic [32:0] co_phase [6];
  logic [32:0] fb_mult, fb_phase, dv_div;

  int checks = 0;
  int failures = 0;
  int n_drdy = 0;

  typedef struct {
    logic        we;
    logic [6:0]  a;
    logic [15:0] exp;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic        we;
    logic [6:0]  a;
    logic [15:0] d;
    logic [15:0] rexp;
    int          sel;
    logic [32:0] oexp;
  } vec_t;
  vec_t tbl [22];

  always #5 clk = ~clk;

  pll_drp_regs #(.CLKFBOUT_MULT(5), .DIVCLK_DIVIDE(1), .CLKOUT_DIVIDE(3)) dut (
    .i_dclk(clk), .i_rst(rst), .i_pwrdwn(pwrdwn), .i_daddr(daddr), .i_den(den),
    .i_dwe(dwe), .i_di(di), .o_do(dout), .o_drdy(drdy),
    .o_clkout0_divide(co_div[0]), .o_clkout1_divide(co_div[1]), .o_clkout2_divide(co_div[2]),
    .o_clkout3_divide(co_div[3]), .o_clkout4_divide(co_div[4]), .o_clkout5_divide(co_div[5]),
    .o_clkout0_duty_cycle_1000(co_duty[0]), .o_clkout1_duty_cycle_1000(co_duty[1]),
    .o_clkout2_duty_cycle_1000(co_duty[2]), .o_clkout3_duty_cycle_1000(co_duty[3]),
    .o_clkout4_duty_cycle_1000(co_duty[4]), .o_clkout5_duty_cycle_1000(co_duty[5]),
    .o_clkout0_phase(co_phase[0]), .o_clkout1_phase(co_phase[1]), .o_clkout2_phase(co_phase[2]),
    .o_clkout3_phase(co_phase[3]), .o_clkout4_phase(co_phase[4]), .o_clkout5_phase(co_phase[5]),
    .o_clkfbout_mult(fb_mult), .o_clkfbout_phase(fb_phase), .o_divclk_divide(dv_div)
  );

  task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic logic [32:0] get_out(input int sel);
    case (sel)
      1:  return co_div[0];
      2:  return co_duty[0];
      3:  return co_phase[0];
      4:  return co_div[1];
      5:  return co_duty[1];
      6:  return fb_mult;
      7:  return dv_div;
      8:  return fb_phase;
      9:  return co_div[5];
      10: return co_div[2];
      11: return co_duty[2];
      default: return '0;
    endcase
  endfunction

  // Scoreboard: every DRDY must match a queued transaction; DO is 0 otherwise.
  always @(negedge clk) begin
    if (drdy) begin
      n_drdy++;
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_drdy actual=1 required=0 do=%h", dout);
      end else begin
        sb_t e;
        e = sb_q.pop_front();
        if (!e.we) chk($sformatf("rd_data_a%02h", e.a), {17'b0, dout}, {17'b0, e.exp});
      end
    end else begin
      chk("do_idle_zero", {17'b0, dout}, 33'd0);
    end
  end

  task automatic txn(input logic we, input logic [6:0] a, input logic [15:0] d, input logic [15:0] exp);
    sb_q.push_back('{we, a, exp});
    @(negedge clk);
    den = 1'b1; dwe = we; daddr = a; di = d;
    @(negedge clk);
    den = 1'b0; dwe = 1'b0;
    for (int i = 0; i < 8 && sb_q.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (sb_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drdy_timeout actual=pending required=done addr=%h", a);
      sb_q.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    rst = 1'b1; pwrdwn = 1'b0; den = 1'b0; dwe = 1'b0; daddr = '0; di = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_drdy", {32'b0, drdy}, 33'd0);
    chk("rst_co0_div", co_div[0], 33'd3);
    chk("rst_co0_duty", co_duty[0], 33'd500);
    chk("rst_co0_phase", co_phase[0], 33'd0);
    chk("rst_fb_mult", fb_mult, 33'd5);
    chk("rst_dv_div", dv_div, 33'd1);

    tbl[0]  = '{1'b0, 7'h08, 16'h0000, 16'h0042, 1,  33'd3};
    tbl[1]  = '{1'b0, 7'h09, 16'h0000, 16'h0080, 2,  33'd500};
    tbl[2]  = '{1'b0, 7'h14, 16'h0000, 16'h0083, 6,  33'd5};
    tbl[3]  = '{1'b0, 7'h15, 16'h0000, 16'h0080, 8,  33'd0};
    tbl[4]  = '{1'b0, 7'h16, 16'h0000, 16'h1041, 7,  33'd1};
    tbl[5]  = '{1'b0, 7'h06, 16'h0000, 16'h0042, 9,  33'd3};
    tbl[6]  = '{1'b1, 7'h08, 16'h0104, 16'h0000, 0,  33'd0};
    tbl[7]  = '{1'b1, 7'h09, 16'h0000, 16'h0000, 1,  33'd8};
    tbl[8]  = '{1'b0, 7'h09, 16'h0000, 16'h0000, 2,  33'd500};
    tbl[9]  = '{1'b1, 7'h09, 16'h0002, 16'h0000, 3,  33'd90000};
    tbl[10] = '{1'b1, 7'h08, 16'h6104, 16'h0000, 3,  33'd106875};
    tbl[11] = '{1'b1, 7'h0B, 16'h0000, 16'h0000, 5,  33'd333};
    tbl[12] = '{1'b1, 7'h0A, 16'h0043, 16'h0000, 4,  33'd4};
    tbl[13] = '{1'b0, 7'h0A, 16'h0000, 16'h0043, 5,  33'd250};
    tbl[14] = '{1'b1, 7'h14, 16'h0285, 16'h0000, 6,  33'd15};
    tbl[15] = '{1'b1, 7'h15, 16'h0001, 16'h0000, 8,  33'd24000};
    tbl[16] = '{1'b1, 7'h16, 16'h0083, 16'h0000, 7,  33'd5};
    tbl[17] = '{1'b1, 7'h16, 16'h1000, 16'h0000, 7,  33'd1};
    tbl[18] = '{1'b1, 7'h0C, 16'h0000, 16'h0000, 10, 33'd128};
    tbl[19] = '{1'b0, 7'h7F, 16'h0000, 16'h0000, 11, 33'd503};
    tbl[20] = '{1'b1, 7'h20, 16'hFFFF, 16'h0000, 0,  33'd0};
    tbl[21] = '{1'b0, 7'h20, 16'h0000, 16'h0000, 0,  33'd0};

    for (int i = 0; i < 22; i++) begin
      txn(tbl[i].we, tbl[i].a, tbl[i].d, tbl[i].rexp);
      if (tbl[i].sel != 0)
        chk($sformatf("vec%0d_out%0d", i, tbl[i].sel), get_out(tbl[i].sel), tbl[i].oexp);
    end

    txn(1'b1, 7'h4F, 16'hBEEF, 16'h0000);
    txn(1'b0, 7'h4F, 16'h0000, 16'hBEEF);

    // DEN held for three edges: only the first is accepted.
    base = n_drdy;
    sb_q.push_back('{1'b1, 7'h18, 16'h0000});
    @(negedge clk); den = 1'b1; dwe = 1'b1; daddr = 7'h18; di = 16'hAAAA;
    @(negedge clk); di = 16'h5555;
    @(negedge clk); daddr = 7'h19; di = 16'h1111;
    @(negedge clk); den = 1'b0; dwe = 1'b0;
    repeat (5) @(negedge clk);
    chk("busy_single_drdy", 33'(n_drdy - base), 33'd1);
    txn(1'b0, 7'h18, 16'h0000, 16'hAAAA);
    txn(1'b0, 7'h19, 16'h0000, 16'h0000);

    // Exact DRDY timing for a read accepted at edge k.
    sb_q.push_back('{1'b0, 7'h18, 16'hAAAA});
    @(negedge clk); den = 1'b1; daddr = 7'h18;
    @(negedge clk); den = 1'b0;
    chk("hs_after_k", {32'b0, drdy}, 33'd0);
    @(negedge clk);
    chk("hs_after_k1", {32'b0, drdy}, 33'd0);
    @(negedge clk);
    chk("hs_after_k2", {32'b0, drdy}, 33'd1);
    @(negedge clk);
    chk("hs_after_k3", {32'b0, drdy}, 33'd0);

    // Reset one edge after an accepted write drops it.
    base = n_drdy;
    @(negedge clk); den = 1'b1; dwe = 1'b1; daddr = 7'h08; di = 16'h1234;
    @(negedge clk); den = 1'b0; dwe = 1'b0; rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_mid_no_drdy", 33'(n_drdy - base), 33'd0);
    chk("rst_mid_co0_div", co_div[0], 33'd3);
    txn(1'b0, 7'h08, 16'h0000, 16'h0042);

    // PWRDWN behaves as reset.
    txn(1'b1, 7'h14, 16'h0285, 16'h0000);
    @(negedge clk); pwrdwn = 1'b1;
    @(negedge clk); pwrdwn = 1'b0;
    chk("pwrdwn_fb_mult", fb_mult, 33'd5);
    txn(1'b0, 7'h4F, 16'h0000, 16'h0000);
    txn(1'b0, 7'h14, 16'h0000, 16'h0083);

    // DWE without DEN is inert.
    @(negedge clk); dwe = 1'b1; daddr = 7'h18; di = 16'hFFFF;
    @(negedge clk); dwe = 1'b0;
    txn(1'b0, 7'h18, 16'h0000, 16'h0000);

    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pll_drp_regs.md
# pll_drp_regs

Dynamic reconfiguration port (DRP) register file and decoder for the behavioural 7-series PLL model. It implements the PLLE2 DRP handshake on DCLK and stores the clock-divider register map. It decodes the stored fields into divide, duty-cycle and phase values, which feed the frequency generators and phase shifters. Fully synchronous, single clock.

## Interface
- CLKFBOUT_MULT, default 5: reset feedback multiplier, range 1..128.
- DIVCLK_DIVIDE, default 1: reset input divider, range 1..128.
- CLKOUT_DIVIDE, default 1: reset divide for all six CLKOUTn, range 1..128.
- DCLK, in, 1: the only clock. All logic runs on its rising edge.
- RST, in, 1: synchronous, active-high reset.
- PWRDWN, in, 1: synchronous, active-high. Identical in effect to RST.
- DADDR, in, 7: register address.
- DEN, in, 1: transaction request, sampled on the DCLK edge.
- DWE, in, 1: write enable, qualified by DEN.
- DI, in, 16: write data.
- DO, out, 16: read data. Valid only while DRDY=1, otherwise 0.
- DRDY, out, 1: one-cycle completion pulse.
- CLKOUTn_DIVIDE (n=0..5), out, 33: decoded divide.
- CLKOUTn_DUTY_CYCLE_1000 (n=0..5), out, 33: duty cycle in per-mille.
- CLKOUTn_PHASE (n=0..5), out, 33: phase in millidegrees.
- CLKFBOUT_MULT, out, 33: decoded feedback multiplier.
- CLKFBOUT_PHASE, out, 33: feedback phase in millidegrees.
- DIVCLK_DIVIDE, out, 33: decoded input divider.

## Operation
- Register map, all 16-bit, read/write, every written bit stored:
  - CLKOUT5: 0x06/0x07.
  - CLKOUT0..4: 0x08/0x09, 0x0A/0x0B, 0x0C/0x0D, 0x0E/0x0F, 0x10/0x11.
  - CLKFBOUT: 0x14/0x15.
  - DIVCLK: 0x16.
  - Plain storage, reset 0: 0x18, 0x19, 0x1A, 0x28, 0x4E, 0x4F.
- Unmapped address: write discarded, read returns 0x0000. DRDY still pulses.
- ClkReg1 fields: [15:13] PHASE_MUX, [11:6] HIGH, [5:0] LOW.
- ClkReg2 fields: [7] EDGE, [6] NO_COUNT, [5:0] DELAY.
- DivReg (0x16) fields: [13] EDGE, [12] NO_COUNT, [11:6] HIGH, [5:0] LOW.
- A HIGH or LOW field value of 0 means 64.
- Decode for each counter:
  - divide = NO_COUNT ? 1 : HIGH+LOW.
  - duty_1000 = NO_COUNT ? 500 : floor(1000·(2·HIGH+EDGE) / (2·divide)).
  - phase = floor((8·DELAY+PHASE_MUX)·45000 / divide).
  - CLKFBOUT uses the same decode, with divide output as CLKFBOUT_MULT. Its duty cycle is not exported.
  - DIVCLK exports only its divide.
- Reset encoding of a divide value d, used for every counter and register:
  - d=1: NO_COUNT=1, HIGH=LOW=1, EDGE=0.
  - Otherwise: HIGH=floor(d/2), LOW=d−HIGH, EDGE=d[0], NO_COUNT=0.
  - In both cases DELAY=0, PHASE_MUX=0, all other bits 0.
  - Decoded reset outputs: divide=d, duty=500, phase=0.
- Decode arithmetic is unsigned, truncating, with 33-bit results. The divide by `divide` may be combinational.

## Timing
- Reset: RST or PWRDWN high at an edge sets the following at that edge:
  - all registers to their reset encodings;
  - decoded outputs to parameter values;
  - DRDY=0, DO=0, busy cleared.
  - Any pending transaction is dropped and never produces DRDY.
- Transaction accepted when DEN=1 at edge k and the block is not busy:
  - Write: the register updates at edge k. Decoded outputs reflect the new value from edge k+1.
  - Read: DO is loaded from the register at edge k+2. A register written at edge k is returned with its new value.
  - DRDY=1 for exactly the cycle following edge k+2.
- Busy: from edge k until DRDY falls at edge k+3. A DEN sampled at k+1 or k+2 is ignored completely: no register change, no extra DRDY.
- Next acceptance: a new DEN is accepted at edge k+3 or later.
- DWE without DEN has no effect.

## Test plan
- Reset, CLKOUT_DIVIDE=3, CLKFBOUT_MULT=5:
  - CLKOUT0_DIVIDE=3, duty 500, phase 0, CLKFBOUT_MULT=5.
  - Read 0x08 -> 0x0042; read 0x09 -> 0x0080.
- Write 0x08=0x0104, then 0x09=0x0000 -> CLKOUT0_DIVIDE=8, duty 500. Then write 0x09=0x0002 and 0x08=0x6104 -> CLKOUT0_PHASE=106875.
- Write 0x0A=0x0043 (HIGH=1, LOW=3) -> CLKOUT1_DIVIDE=4, duty 250.
- Feedback and input divider:
  - Write 0x14=0x0285 -> CLKFBOUT_MULT=15.
  - Write 0x16=0x0083 -> DIVCLK_DIVIDE=5.
  - Write 0x16=0x1000 -> DIVCLK_DIVIDE=1.
- Handshake:
  - DEN at k -> DRDY only in the cycle after k+2.
  - Second DEN at k+1 -> ignored, single DRDY.
  - Read 0x7F -> 0x0000 with DRDY.
- Reset mid-operation: RST at k+1 after a write at k -> no DRDY, register back to its reset encoding.
